// File: rtl/seq_mon_pkg.sv
// seq_mon_pkg
//   Shared definitions for seq_change_monitor:
//   - default parameter values for the monitor and its record queue
//   - rec_t: packed record layout {first, stamp, value} at the default sizes
//     (the monitor builds its own parameterized word with the same field order)
//   - sat_inc: saturating increment used for the drop counter
package seq_mon_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_TS_WIDTH   = 16;
    localparam int DEF_DROP_WIDTH = 8;

    typedef struct packed {
        logic                    first;
        logic [DEF_TS_WIDTH-1:0] stamp;
        logic [DEF_WIDTH-1:0]    value;
    } rec_t;

    // Increment cnt unless it has already reached max_val. Callers narrow
    // the result back to their own counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [31:0] max_val);
        return (cnt >= max_val) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/seq_change_monitor_fifo.sv
// sync_fifo
//   Single-clock FIFO with combinational head read.
//   Ports:
//     clk, rst_n     clock / asynchronous active-low reset
//     push, wdata    write request and data; accepted when not full, or when
//                    full and a pop is accepted in the same cycle
//     pop            read request; ignored while empty
//     rdata          head entry, reads 0 while empty
//     full, empty    occupancy flags
//     level          current occupancy (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable
    // when the index bits match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot, so a full queue still takes the push.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; entries are only visible
    // between the pointers, and rdata is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/seq_change_monitor.sv
// seq_change_monitor
//   Samples sample_in every clock and records each value change as a
//   timestamped entry in a small FIFO, drained over a valid/ready interface.
//   Ports:
//     clk, rst_n     clock / asynchronous active-low reset
//     enable         recording enable; while low, prev/armed hold
//     sample_in      watched bus
//     rec_valid      head record present
//     rec_ready      consumer accepts the head record
//     rec_first      head record is the first one since reset
//     rec_time       timestamp (pre-increment ts) of the head record
//     rec_value      value of the head record
//     level          queue occupancy
//     drop_count     records refused by a full queue, saturating
module seq_change_monitor
    import seq_mon_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int TS_WIDTH   = DEF_TS_WIDTH,
    parameter int DROP_WIDTH = DEF_DROP_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         sample_in,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic                     rec_first,
    output logic [TS_WIDTH-1:0]      rec_time,
    output logic [WIDTH-1:0]         rec_value,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_WIDTH-1:0]    drop_count
);

    localparam int          RW       = 1 + TS_WIDTH + WIDTH;
    localparam logic [31:0] DROP_MAX = 32'({DROP_WIDTH{1'b1}});

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic                  armed_q, armed_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    logic                  change;
    logic                  pop;
    logic                  drop_event;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [RW-1:0]         wr_word;
    logic [RW-1:0]         head_word;

    always_comb begin
        // Case inequality lets X/Z transitions register in simulation;
        // synthesis reduces it to an ordinary compare.
        change     = enable && (armed_q || (sample_in !== prev_q));
        pop        = rec_valid && rec_ready;
        drop_event = change && fifo_full && !pop;
        ts_d       = ts_q + TS_WIDTH'(1);
        // prev tracks the last *detected* change, even if the queue refused it,
        // so a dropped value is not reported again.
        prev_d     = change ? sample_in : prev_q;
        armed_d    = armed_q && !change;
        drop_d     = drop_event ? DROP_WIDTH'(sat_inc(32'(drop_q), DROP_MAX)) : drop_q;
        wr_word    = {armed_q, ts_q, sample_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q    <= '0;
            prev_q  <= '0;
            armed_q <= 1'b1;
            drop_q  <= '0;
        end else begin
            ts_q    <= ts_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            drop_q  <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (change),
        .pop   (pop),
        .wdata (wr_word),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign rec_valid = !fifo_empty;
    assign {rec_first, rec_time, rec_value} = head_word;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_seq_change_monitor.sv
// Scoreboard bench for seq_change_monitor. A reference model on the rising
// edge decides from the observable rules which records exist; a monitor on
// the falling edge compares DUT outputs against the expected queue head and
// retires entries when the consumer accepts them. A second instance with
// TS_WIDTH=4 runs on the same stimulus to cover timestamp wrap.
module tb_seq_change_monitor;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 4;
    localparam int TS_WIDTH   = 16;
    localparam int DROP_WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  enable = 1'b0;
    logic [WIDTH-1:0]      sample_in = '0;
    logic                  rec_ready = 1'b0;

    logic                  rec_valid, rec_first;
    logic [TS_WIDTH-1:0]   rec_time;
    logic [WIDTH-1:0]      rec_value;
    logic [2:0]            level;
    logic [DROP_WIDTH-1:0] drop_count;

    logic                  rec_valid4, rec_first4;
    logic [3:0]            rec_time4;
    logic [WIDTH-1:0]      rec_value4;
    logic [2:0]            level4;
    logic [DROP_WIDTH-1:0] drop_count4;

    seq_change_monitor #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH), .DROP_WIDTH(DROP_WIDTH)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_first(rec_first),
        .rec_time(rec_time), .rec_value(rec_value), .level(level),
        .drop_count(drop_count)
    );

    seq_change_monitor #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(4), .DROP_WIDTH(DROP_WIDTH)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
        .rec_valid(rec_valid4), .rec_ready(rec_ready), .rec_first(rec_first4),
        .rec_time(rec_time4), .rec_value(rec_value4), .level(level4),
        .drop_count(drop_count4)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          first;
        int unsigned t;
        logic [7:0]  v;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    bit          recorded;
    logic [7:0]  last;
    int unsigned drops;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        cyc      = 0;
        recorded = 0;
        last     = '0;
        drops    = 0;
    endtask

    // Reference model: a record is due whenever recording is enabled and
    // either nothing was recorded yet or the value differs from the last one.
    // The monitor has already retired this cycle's pop, so sb.size() < DEPTH
    // means there is room.
    always @(posedge clk) begin
        if (rst_n) begin
            if (enable && (!recorded || sample_in != last)) begin
                if (sb.size() < DEPTH) begin
                    exp_t e;
                    e.first = !recorded;
                    e.t     = cyc % 65536;
                    e.v     = sample_in;
                    sb.push_back(e);
                end else if (drops < 255) begin
                    drops++;
                end
                recorded = 1;
                last     = sample_in;
            end
            cyc++;
        end
    end

    // Monitor: compares the presented head and counters, then retires the
    // head if the consumer is accepting it at the coming edge.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            check("rec_valid",  32'(rec_valid),  32'(sb.size() != 0));
            check("level",      32'(level),      32'(sb.size()));
            check("drop_count", 32'(drop_count), drops);
            check("rec_valid4", 32'(rec_valid4), 32'(sb.size() != 0));
            check("level4",     32'(level4),     32'(sb.size()));
            check("drop4",      32'(drop_count4), drops);
            if (sb.size() != 0) begin
                check("rec_first",  32'(rec_first),  32'(sb[0].first));
                check("rec_time",   32'(rec_time),   sb[0].t);
                check("rec_value",  32'(rec_value),  32'(sb[0].v));
                check("rec_time4",  32'(rec_time4),  sb[0].t % 16);
                check("rec_value4", 32'(rec_value4), 32'(sb[0].v));
                if (rec_ready) begin
                    void'(sb.pop_front());
                end
            end else begin
                check("empty_first", 32'(rec_first), 32'd0);
                check("empty_time",  32'(rec_time),  32'd0);
                check("empty_value", 32'(rec_value), 32'd0);
            end
        end
    end

    task automatic step(input bit en, input logic [7:0] v, input bit rdy);
        @(negedge clk);
        enable    = en;
        sample_in = v;
        rec_ready = rdy;
    endtask

    // Reset pulse between edges: outputs must clear before the next edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_valid", 32'(rec_valid), 32'd0);
        check("async_rst_level", 32'(level),     32'd0);
        check("async_rst_time",  32'(rec_time),  32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        enable    = 1'b1;
        sample_in = 8'h00;
        rec_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(rec_valid),  32'd0);
        check("reset_level", 32'(level),      32'd0);
        check("reset_drop",  32'(drop_count), 32'd0);
        rst_n = 1'b1;

        // Initial record at edge 0, then a single change at edge 5.
        repeat (4) step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h5A, 1'b1);
        repeat (3) step(1'b1, 8'h5A, 1'b1);

        // Overfill with consumer stalled, then push+pop while full, then drain.
        for (int i = 0; i < 6; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
        step(1'b1, 8'h70, 1'b1);
        repeat (6) step(1'b1, 8'h70, 1'b1);

        // Value leaves and returns while disabled: no record; then a real change.
        step(1'b1, 8'h5A, 1'b1);
        step(1'b0, 8'h11, 1'b1);
        step(1'b0, 8'h5A, 1'b1);
        step(1'b1, 8'h5A, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        repeat (2) step(1'b1, 8'h22, 1'b1);

        // Three records queued, then asynchronous reset mid-cycle.
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        pulse_reset();

        // Change at edge 17: the 4-bit timestamp instance shows 1.
        repeat (16) step(1'b1, 8'h33, 1'b1);
        step(1'b1, 8'h44, 1'b1);
        repeat (2) step(1'b1, 8'h44, 1'b1);

        // Drop counter saturation with the consumer stalled.
        for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 1'b0);
        repeat (6) step(1'b1, 8'h2B, 1'b1);

        // Randomized traffic from a fresh reset; small value alphabet gives repeats.
        pulse_reset();
        repeat (3000) begin
            step($urandom_range(0, 99) < 85, 8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
